sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Parametrised pixel-drawing engine that turns one command into a stream of one-pixel-per-cycle writes for the vga_adapter (x, y, colour, plot).
- Successor to the fixed 16x16 sprite/clear datapath. Adds:
  - configurable screen, sprite size and frame count;
  - a valid/ready command handshake;
  - screen-edge clipping;
  - colour-key transparency;
  - a solid-rectangle erase mode.
- Sits between game control FSMs and vga_adapter. Reads sprite pixels from an external synchronous ROM (ramGraphics-style, 1-cycle read latency).

Parameters:
- SCREEN_W, 320, visible width in pixels
- SCREEN_H, 240, visible height in pixels
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- SPR_W, 16, sprite width (power of 2)
- SPR_H, 16, sprite height (power of 2)
- FRAMES, 8, sprite frames stored in ROM (power of 2)
- COLOUR_W, 15, colour width (5:5:5)
- KEY_COLOUR, 15'h7C1F, transparent colour key (magenta)
- A_W, log2(FRAMES*SPR_W*SPR_H) = 11, ROM address width

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=CLEAR, 1=SPRITE, 2=RECT, 3=reserved
- cmd_x  in  X_W  top-left x (SPRITE/RECT)
- cmd_y  in  Y_W  top-left y (SPRITE/RECT)
- cmd_frame  in  log2(FRAMES)  sprite frame index
- cmd_colour  in  COLOUR_W  fill colour (CLEAR/RECT)
- cmd_transp  in  1  enable colour-key transparency (SPRITE)
- rom_addr  out  A_W  sprite ROM address
- rom_q  in  COLOUR_W  ROM data, valid the cycle after rom_addr
- x  out  X_W  pixel x to vga_adapter
- y  out  Y_W  pixel y to vga_adapter
- colour  out  COLOUR_W  pixel colour
- plot  out  1  write strobe
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (sync, active-high) values:
  - x, y, colour, rom_addr, plot, done, busy all 0; cmd_ready 0 during reset.
  - FSM to IDLE; counters to 0; no pending done after reset.
- Reset mid-command aborts the command immediately, with no done pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid & cmd_ready: latch all cmd_* fields, clear counters i=j=0, go to RUN.
  - busy=1 from the cycle after accept.
- RUN (issue stage), one pixel slot per cycle, row-major: i increments; when i hits its limit, i=0 and j increments.
  - CLEAR: i over 0..SCREEN_W-1, j over 0..SCREEN_H-1. N = SCREEN_W*SCREEN_H.
  - SPRITE / RECT: i over 0..SPR_W-1, j over 0..SPR_H-1. N = SPR_W*SPR_H.
  - Op 3: N = 1, slot always suppressed.
  - rom_addr = {frame, j[log2 SPR_H-1:0], i[log2 SPR_W-1:0]}, driven from registered counters. Static 0 for non-SPRITE ops.
  - After the last slot is issued, go to DRAIN.
- Output stage (1-cycle latency): the slot issued at cycle t appears on x/y/colour/plot at t+1.
  - px = cmd_x + i, computed at X_W+1 bits (no wrap).
  - py = cmd_y + j, computed at Y_W+1 bits (no wrap).
  - CLEAR uses px=i, py=j.
  - plot=1 unless any suppression rule applies:
    - px >= SCREEN_W or py >= SCREEN_H (clipped);
    - SPRITE with cmd_transp=1 and rom_q == KEY_COLOUR;
    - op 3.
  - colour = rom_q for SPRITE; cmd_colour for CLEAR/RECT.
  - When plot=0, x/y/colour hold their previous values.
- DRAIN:
  - Emits the final output slot.
  - done=1 in the same cycle as the last output slot.
  - busy=0 and go to IDLE next cycle.
  - cmd_ready=1 the cycle after done.
- Timing from accept at cycle A:
  - first output slot at A+2;
  - done at A+N+1;
  - next accept possible at A+N+2.
- cmd_valid while busy is ignored. The command must be held by the requester until accepted.
- Sprite fully off-screen (cmd_x >= SCREEN_W): full N-cycle duration, zero plots, done still pulses.

Test Plan:
- Reset, then CLEAR with cmd_colour=15'h0000 → 76800 plots in consecutive cycles; (x,y) goes (0,0)…(319,239) row-major; done one cycle at A+76801; cmd_ready=1 at A+76802.
- SPRITE frame 2 at (100,50), transp=0, ROM preloaded with addr value → 256 plots.
  - rom_addr 512..767.
  - Pixel (i=3, j=1) appears at (103,51) with colour=531.
  - done at A+257.
- SPRITE at (310,230), transp=0 → exactly 100 plots covering x 310..319, y 230..239; no x/y wrap; done at A+257.
- SPRITE transp=1, ROM frame 0 with a checkerboard of 15'h7C1F and 15'h03E0 → 128 plots, all colour 15'h03E0; with transp=0 → 256 plots.
- RECT at (0,0), colour 15'h7FFF, followed by SPRITE with cmd_valid held high → first accepted at A, second accepted at A+258; no lost or overlapping plots.
- Assert reset at slot 40 of a SPRITE → the next cycle has plot=0, busy=0, done=0, all outputs 0; no done pulse afterwards; cmd_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/sprite_blitter_if.sv
// Command channel between a game-control requester and the sprite blitter.
// The requester drives the command fields and cmd_valid; the blitter answers
// with cmd_ready. A command is taken on a cycle where both are high.
interface sprite_blitter_if #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int FRAME_W  = 3,
    parameter int COLOUR_W = 15
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [X_W-1:0]      cmd_x;
    logic [Y_W-1:0]      cmd_y;
    logic [FRAME_W-1:0]  cmd_frame;
    logic [COLOUR_W-1:0] cmd_colour;
    logic                cmd_transp;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_frame, cmd_colour, cmd_transp,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_frame, cmd_colour, cmd_transp,
        output cmd_ready
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: turns one command (CLEAR, SPRITE, RECT) into a row-major
// stream of one-pixel-per-cycle writes for the VGA adapter. Pixel slots are
// issued from registered counters, the sprite ROM answers one cycle later,
// and the output stage applies screen clipping and colour-key transparency.
module sprite_blitter #(
    parameter int                  SCREEN_W   = 320,
    parameter int                  SCREEN_H   = 240,
    parameter int                  X_W        = 9,
    parameter int                  Y_W        = 8,
    parameter int                  SPR_W      = 16,
    parameter int                  SPR_H      = 16,
    parameter int                  FRAMES     = 8,
    parameter int                  COLOUR_W   = 15,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = 15'h7C1F,
    parameter int                  A_W        = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                clk,
    input  logic                reset,
    sprite_blitter_if.slave     cmd_if,
    output logic [A_W-1:0]      rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    localparam int FRAME_W = $clog2(FRAMES);
    localparam int SW_W    = $clog2(SPR_W);
    localparam int SH_W    = $clog2(SPR_H);

    localparam logic [1:0] OP_CLEAR  = 2'd0;
    localparam logic [1:0] OP_SPRITE = 2'd1;
    localparam logic [1:0] OP_RECT   = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    localparam logic [X_W-1:0] CLR_I_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] CLR_J_MAX = Y_W'(SCREEN_H - 1);
    localparam logic [X_W-1:0] SPR_I_MAX = X_W'(SPR_W - 1);
    localparam logic [Y_W-1:0] SPR_J_MAX = Y_W'(SPR_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      i_q, i_d;
    logic [Y_W-1:0]      j_q, j_d;
    logic [1:0]          op_q, op_d;
    logic [X_W-1:0]      cx_q, cx_d;
    logic [Y_W-1:0]      cy_q, cy_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [COLOUR_W-1:0] fill_q, fill_d;
    logic                transp_q, transp_d;
    logic                s_valid_q, s_valid_d;
    logic [X_W:0]        s_px_q, s_px_d;
    logic [Y_W:0]        s_py_q, s_py_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;

    logic [X_W-1:0]      i_max;
    logic [Y_W-1:0]      j_max;
    logic                last_slot;
    logic                clipped;
    logic                keyed;

    // Issue stage: command latch, slot counters and the pixel-slot pipeline register.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        op_d      = op_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        frame_d   = frame_q;
        fill_d    = fill_q;
        transp_d  = transp_q;
        s_valid_d = 1'b0;
        s_px_d    = s_px_q;
        s_py_d    = s_py_q;

        case (op_q)
            OP_CLEAR: begin
                i_max = CLR_I_MAX;
                j_max = CLR_J_MAX;
            end
            OP_RSVD: begin
                i_max = '0;
                j_max = '0;
            end
            default: begin
                i_max = SPR_I_MAX;
                j_max = SPR_J_MAX;
            end
        endcase
        last_slot = (i_q == i_max) && (j_q == j_max);

        case (state_q)
            IDLE: begin
                if (cmd_if.cmd_valid) begin
                    op_d     = cmd_if.cmd_op;
                    cx_d     = cmd_if.cmd_x;
                    cy_d     = cmd_if.cmd_y;
                    frame_d  = cmd_if.cmd_frame;
                    fill_d   = cmd_if.cmd_colour;
                    transp_d = cmd_if.cmd_transp;
                    i_d      = '0;
                    j_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                s_valid_d = 1'b1;
                if (op_q == OP_CLEAR) begin
                    s_px_d = {1'b0, i_q};
                    s_py_d = {1'b0, j_q};
                end else begin
                    s_px_d = {1'b0, cx_q} + {1'b0, i_q};
                    s_py_d = {1'b0, cy_q} + {1'b0, j_q};
                end
                if (last_slot) begin
                    state_d = DRAIN;
                end else if (i_q == i_max) begin
                    i_d = '0;
                    j_d = j_q + Y_W'(1);
                end else begin
                    i_d = i_q + X_W'(1);
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage: decide whether the slot plots, and hold x/y/colour when it does not.
    always_comb begin
        clipped  = (s_px_q >= (X_W+1)'(SCREEN_W)) || (s_py_q >= (Y_W+1)'(SCREEN_H));
        keyed    = (op_q == OP_SPRITE) && transp_q && (rom_q == KEY_COLOUR);
        plot     = s_valid_q && (op_q != OP_RSVD) && !clipped && !keyed;
        x        = plot ? s_px_q[X_W-1:0] : x_q;
        y        = plot ? s_py_q[Y_W-1:0] : y_q;
        colour   = plot ? ((op_q == OP_SPRITE) ? rom_q : fill_q) : colour_q;
        x_d      = x;
        y_d      = y;
        colour_d = colour;
        busy     = (state_q != IDLE);
        done     = (state_q == DRAIN);
        cmd_if.cmd_ready = (state_q == IDLE) && !reset;
        rom_addr = ((state_q == RUN) && (op_q == OP_SPRITE))
                 ? {frame_q, j_q[SH_W-1:0], i_q[SW_W-1:0]} : '0;
    end

    // State register; reset aborts any command in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            op_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            frame_q   <= '0;
            fill_q    <= '0;
            transp_q  <= 1'b0;
            s_valid_q <= 1'b0;
            s_px_q    <= '0;
            s_py_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            op_q      <= op_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            frame_q   <= frame_d;
            fill_q    <= fill_d;
            transp_q  <= transp_d;
            s_valid_q <= s_valid_d;
            s_px_q    <= s_px_d;
            s_py_q    <= s_py_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: a reference model expands each accepted
// command into the list of pixels it must plot and the cycle of its done
// pulse; a monitor pops and compares those as the DUT produces them.
module tb_sprite_blitter;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int SPR_W    = 16;
    localparam int SPR_H    = 16;
    localparam int KEY      = 'h7C1F;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    typedef struct {
        int at_cycle;
        int plots;
    } done_t;

    logic        clk;
    logic        reset;
    logic [10:0] rom_addr;
    logic [14:0] rom_q;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [14:0] colour;
    logic        plot;
    logic        busy;
    logic        done;

    logic [14:0] rom_mem [0:2047];

    pix_t  exp_q[$];
    done_t done_q[$];

    int cyc        = 0;
    int checks     = 0;
    int failures   = 0;
    int plot_seen  = 0;

    sprite_blitter_if #(.X_W(9), .Y_W(8), .FRAME_W(3), .COLOUR_W(15)) cmd_if ();

    sprite_blitter dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_if   (cmd_if.slave),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    // 50 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter, stable when sampled on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous sprite ROM with one cycle of read latency.
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) cycle=%0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Reference model: pixels a command must plot, in row-major order, plus its done cycle.
    task automatic model_cmd(input int op, input int x0, input int y0, input int fr,
                             input int col, input int tr, input int acc);
        int   n;
        int   cnt;
        pix_t p;
        done_t d;
        n   = 1;
        cnt = 0;
        if (op == 0) begin
            n = SCREEN_W * SCREEN_H;
            for (int jj = 0; jj < SCREEN_H; jj++) begin
                for (int ii = 0; ii < SCREEN_W; ii++) begin
                    p.px = ii;
                    p.py = jj;
                    p.pc = col;
                    exp_q.push_back(p);
                    cnt++;
                end
            end
        end else if (op == 1 || op == 2) begin
            n = SPR_W * SPR_H;
            for (int jj = 0; jj < SPR_H; jj++) begin
                for (int ii = 0; ii < SPR_W; ii++) begin
                    int c;
                    if (x0 + ii < SCREEN_W && y0 + jj < SCREEN_H) begin
                        c = (op == 1) ? int'(rom_mem[fr * SPR_W * SPR_H + jj * SPR_W + ii]) : col;
                        if (!(op == 1 && tr != 0 && c == KEY)) begin
                            p.px = x0 + ii;
                            p.py = y0 + jj;
                            p.pc = c;
                            exp_q.push_back(p);
                            cnt++;
                        end
                    end
                end
            end
        end
        d.at_cycle = acc + n + 1;
        d.plots    = cnt;
        done_q.push_back(d);
    endtask

    task automatic finish_now(input string why);
        failures++;
        $display("[TB] FAIL %s", why);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] aborting");
    endtask

    // Present a command and hold it until accepted; returns the accept cycle.
    task automatic applyStimulus(input int op, input int x0, input int y0, input int fr,
                                 input int col, input int tr, output int acc);
        int k;
        @(negedge clk);
        cmd_if.cmd_op     = 2'(op);
        cmd_if.cmd_x      = 9'(x0);
        cmd_if.cmd_y      = 8'(y0);
        cmd_if.cmd_frame  = 3'(fr);
        cmd_if.cmd_colour = 15'(col);
        cmd_if.cmd_transp = 1'(tr);
        cmd_if.cmd_valid  = 1'b1;
        for (k = 0; k < 100000 && !cmd_if.cmd_ready; k++) @(negedge clk);
        if (!cmd_if.cmd_ready) finish_now("accept_timeout");
        acc = cyc;
        model_cmd(op, x0, y0, fr, col, tr, acc);
        @(posedge clk);
    endtask

    task automatic release_cmd();
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!busy && done_q.size() == 0) break;
        end
        checkOutput("idle_reached", int'(!busy && done_q.size() == 0), 1);
    endtask

    // cmd_ready must stay low through the done cycle and rise the cycle after.
    task automatic check_ready_window(input int acc, input int n);
        while (cyc < acc + n + 1) @(negedge clk);
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("ready_during_done", int'(cmd_if.cmd_ready), 0);
        @(negedge clk);
        checkOutput("ready_after_done", int'(cmd_if.cmd_ready), 1);
        checkOutput("busy_after_done", int'(busy), 0);
    endtask

    // Monitor: compare every plotted pixel and every done pulse against the model.
    always @(negedge clk) begin
        if (reset) begin
            plot_seen = 0;
        end else begin
            if (plot) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_plot", 1, 0);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    checkOutput("pixel_x", int'(x), e.px);
                    checkOutput("pixel_y", int'(y), e.py);
                    checkOutput("pixel_colour", int'(colour), e.pc);
                end
                plot_seen++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    checkOutput("done_cycle", cyc, d.at_cycle);
                    checkOutput("plot_count", plot_seen, d.plots);
                end
                plot_seen = 0;
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #(99000 * 10);
        finish_now("watchdog_expired");
    end

    // Directed scenarios followed by randomized commands.
    initial begin
        int acc;
        int acc2;
        reset = 1'b1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_op     = '0;
        cmd_if.cmd_x      = '0;
        cmd_if.cmd_y      = '0;
        cmd_if.cmd_frame  = '0;
        cmd_if.cmd_colour = '0;
        cmd_if.cmd_transp = 1'b0;
        for (int a = 0; a < 2048; a++) rom_mem[a] = 15'(a);

        repeat (3) @(negedge clk);
        checkOutput("reset_plot", int'(plot), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_x", int'(x), 0);
        checkOutput("reset_y", int'(y), 0);
        checkOutput("reset_colour", int'(colour), 0);
        checkOutput("reset_rom_addr", int'(rom_addr), 0);
        checkOutput("reset_cmd_ready", int'(cmd_if.cmd_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] full-screen clear");
        applyStimulus(0, 0, 0, 0, 'h0000, 0, acc);
        release_cmd();
        check_ready_window(acc, SCREEN_W * SCREEN_H);
        wait_idle(100);

        $display("[TB] sprite frame 2 at (100,50)");
        applyStimulus(1, 100, 50, 2, 0, 0, acc);
        release_cmd();
        check_ready_window(acc, 256);
        wait_idle(100);

        $display("[TB] sprite clipped at bottom-right corner");
        applyStimulus(1, 310, 230, 1, 0, 0, acc);
        release_cmd();
        check_ready_window(acc, 256);
        wait_idle(100);

        $display("[TB] colour-key transparency on a checkerboard");
        for (int jj = 0; jj < SPR_H; jj++)
            for (int ii = 0; ii < SPR_W; ii++)
                rom_mem[jj * SPR_W + ii] = ((ii + jj) % 2 == 0) ? 15'h7C1F : 15'h03E0;
        applyStimulus(1, 20, 20, 0, 0, 1, acc);
        release_cmd();
        wait_idle(400);
        applyStimulus(1, 40, 20, 0, 0, 0, acc);
        release_cmd();
        wait_idle(400);

        $display("[TB] rect then sprite with valid held");
        applyStimulus(2, 0, 0, 0, 'h7FFF, 0, acc);
        applyStimulus(1, 200, 100, 3, 0, 0, acc2);
        checkOutput("b2b_accept_gap", acc2 - acc, 258);
        release_cmd();
        wait_idle(400);

        $display("[TB] reset in the middle of a sprite");
        applyStimulus(1, 10, 10, 2, 0, 0, acc);
        release_cmd();
        while (cyc < acc + 41) @(negedge clk);
        #2;
        checkOutput("pixels_left_at_reset", exp_q.size(), 216);
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        checkOutput("abort_plot", int'(plot), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_x", int'(x), 0);
        checkOutput("abort_y", int'(y), 0);
        checkOutput("abort_colour", int'(colour), 0);
        checkOutput("abort_rom_addr", int'(rom_addr), 0);
        checkOutput("abort_cmd_ready", int'(cmd_if.cmd_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", int'(cmd_if.cmd_ready), 1);
        repeat (300) @(negedge clk);

        $display("[TB] randomized commands");
        for (int a = 0; a < 2048; a++)
            rom_mem[a] = ($urandom_range(0, 3) == 0) ? 15'h7C1F : 15'($urandom);
        for (int n = 0; n < 10; n++) begin
            int op;
            op = $urandom_range(1, 3);
            applyStimulus(op, $urandom_range(0, 330), $urandom_range(0, 250),
                          $urandom_range(0, 7), $urandom_range(0, 'h7FFF),
                          $urandom_range(0, 1), acc);
            release_cmd();
            wait_idle(400);
        end

        checkOutput("leftover_pixels", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
